// File: rtl/alu32_pkg.sv
// Shared definitions for the 32-bit add/sub ALU operand loader.
//   DATA_W / BYTE_W / NUM_BYTES : datapath geometry (DATA_W must be a multiple of BYTE_W)
//   state_e                     : loader FSM states
//   res_t                       : captured ALU result and flags
//   lane_w()                    : width of a byte-lane index for a given lane count
package alu32_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NUM_BYTES = DATA_W / BYTE_W;

  typedef enum logic [1:0] {
    StLoadA,
    StLoadB,
    StExec,
    StHold
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              carry;
    logic              zero;
    logic              overflow;
  } res_t;

  // A single-lane datapath still needs a 1-bit index to keep port widths legal.
  function automatic int unsigned lane_w(input int unsigned num_lanes);
    return (num_lanes > 1) ? $clog2(num_lanes) : 1;
  endfunction

endpackage

// File: rtl/alu32_byte_asm.sv
// Operand assembly register: DATA_W bits written one BYTE_W lane at a time.
//   clk, rst_n : clock, asynchronous active-low reset (register clears to 0)
//   clear_i    : synchronous clear to 0, wins over a write in the same cycle
//   we_i       : write byte_i into lane lane_i; other lanes keep their value
//   data_o     : assembled operand
module alu32_byte_asm #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BYTE_W = 8,
  parameter int unsigned LANE_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              we_i,
  input  logic [LANE_W-1:0] lane_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (clear_i) begin
      data_d = '0;
    end else if (we_i) begin
      data_d[BYTE_W*lane_i +: BYTE_W] = byte_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/alu32_operand_loader.sv
// Feeder and result-capture stage for a combinational 32-bit add/sub ALU.
// Operands A then B arrive little-endian over a byte valid/ready stream; the op select is
// taken with the last B byte. One EXEC cycle later the ALU outputs are registered and
// offered downstream on a valid/ready result port.
//   clk, rst_n              : clock, asynchronous active-low reset
//   clear                   : synchronous abort back to loading A (op_count kept)
//   in_valid/in_ready/in_byte/in_op : byte stream and add(0)/sub(1) select
//   alu_a/alu_b/alu_sub_add : registered operands and op to the ALU
//   alu_result/alu_carry/alu_zero/alu_overflow : ALU outputs
//   res_valid/res_ready/res_data/res_carry/res_zero/res_overflow : captured result
//   op_count                : completed result handshakes, wraps
module alu32_operand_loader #(
  parameter int unsigned DATA_W = alu32_pkg::DATA_W,
  parameter int unsigned BYTE_W = alu32_pkg::BYTE_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              in_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_sub_add,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_carry,
  output logic              res_zero,
  output logic              res_overflow,
  output logic [CNT_W-1:0]  op_count
);

  import alu32_pkg::*;

  localparam int unsigned      NumBytes = DATA_W / BYTE_W;
  localparam int unsigned      LaneW    = lane_w(NumBytes);
  localparam logic [LaneW-1:0] LastLane = LaneW'(NumBytes - 1);

  state_e             state_d, state_q;
  logic [LaneW-1:0]   byte_cnt_d, byte_cnt_q;
  logic               sub_d, sub_q;
  res_t               res_d, res_q;
  logic               res_valid_d, res_valid_q;
  logic [CNT_W-1:0]   op_count_d, op_count_q;

  logic accept, we_a, we_b, last_byte;

  assign in_ready  = (state_q == StLoadA) || (state_q == StLoadB);
  // clear drops any byte offered in the same cycle.
  assign accept    = in_valid && in_ready && !clear;
  assign we_a      = accept && (state_q == StLoadA);
  assign we_b      = accept && (state_q == StLoadB);
  assign last_byte = (byte_cnt_q == LastLane);

  alu32_byte_asm #(
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W),
    .LANE_W (LaneW)
  ) u_asm_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear),
    .we_i    (we_a),
    .lane_i  (byte_cnt_q),
    .byte_i  (in_byte),
    .data_o  (alu_a)
  );

  alu32_byte_asm #(
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W),
    .LANE_W (LaneW)
  ) u_asm_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear),
    .we_i    (we_b),
    .lane_i  (byte_cnt_q),
    .byte_i  (in_byte),
    .data_o  (alu_b)
  );

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    sub_d       = sub_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    op_count_d  = op_count_q;

    if (clear) begin
      state_d     = StLoadA;
      byte_cnt_d  = '0;
      sub_d       = 1'b0;
      res_d       = '0;
      res_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StLoadA: begin
          if (accept) begin
            if (last_byte) begin
              byte_cnt_d = '0;
              state_d    = StLoadB;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end
        end
        StLoadB: begin
          if (accept) begin
            if (last_byte) begin
              byte_cnt_d = '0;
              sub_d      = in_op;
              state_d    = StExec;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end
        end
        StExec: begin
          // Operands and op have been stable for a full cycle, so the ALU output is settled.
          res_d.data     = alu_result;
          res_d.carry    = alu_carry;
          res_d.zero     = alu_zero;
          res_d.overflow = alu_overflow;
          res_valid_d    = 1'b1;
          state_d        = StHold;
        end
        StHold: begin
          if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
            op_count_d  = op_count_q + 1'b1;
            byte_cnt_d  = '0;
            state_d     = StLoadA;
          end
        end
        default: state_d = StLoadA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StLoadA;
      byte_cnt_q  <= '0;
      sub_q       <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      sub_q       <= sub_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign alu_sub_add  = sub_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_q.data;
  assign res_carry    = res_q.carry;
  assign res_zero     = res_q.zero;
  assign res_overflow = res_q.overflow;
  assign op_count     = op_count_q;

endmodule

// File: doc/alu32_operand_loader.md
Name: alu32_operand_loader

Overview:
Upstream feeder and result-capture stage for the 32-bit combinational add/sub ALU.
- Assembles operands A and B from an 8-bit byte stream using a valid/ready handshake.
- Drives the ALU with stable registered operands and the add/sub select.
- Captures the ALU result and flags, then offers them downstream through a valid/ready handshake.
- Bridges switch/byte-level input (board or testbench) to the 32-bit datapath.

Parameters:
DATA_W, 32, operand/result width; must be an integer multiple of BYTE_W.
BYTE_W, 8, width of one input byte.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous abort; returns the block to the load-A state
in_valid  in  1  in_byte is valid
in_ready  out  1  block can accept a byte
in_byte  in  BYTE_W  operand byte, little-endian (least significant byte first)
in_op  in  1  add(0)/sub(1); sampled with the final byte of B
alu_a  out  DATA_W  operand A to ALU
alu_b  out  DATA_W  operand B to ALU
alu_sub_add  out  1  op select to ALU
alu_result  in  DATA_W  ALU result
alu_carry  in  1  ALU carry flag
alu_zero  in  1  ALU zero flag
alu_overflow  in  1  ALU overflow flag
res_valid  out  1  captured result available
res_ready  in  1  downstream accepts result
res_data  out  DATA_W  captured result
res_carry, res_zero, res_overflow  out  1 each  captured flags
op_count  out  CNT_W  number of completed result handshakes

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=LOAD_A, byte_cnt=0.
  - alu_a, alu_b, alu_sub_add, res_data and all res flags = 0.
  - res_valid=0, op_count=0.
  - in_ready=1, because it is decoded from state.
- Byte transfer occurs when in_valid && in_ready on a rising edge.
- in_ready = 1 in LOAD_A and LOAD_B; 0 in EXEC and HOLD.
- NUM_BYTES = DATA_W/BYTE_W.
- LOAD_A:
  - Each accepted byte is written into lane byte_cnt of alu_a; other lanes are unchanged.
  - byte_cnt increments by 1.
  - On the byte accepted with byte_cnt==NUM_BYTES-1: byte_cnt goes to 0 and state goes to LOAD_B.
- LOAD_B:
  - Same lane-write behaviour, into alu_b.
  - On the final byte, in_op is latched into alu_sub_add and state goes to EXEC.
- EXEC (exactly one cycle; operands have been stable since the preceding edge):
  - At the end of the cycle, alu_result and the three flags are registered into res_*.
  - res_valid is set to 1 and state goes to HOLD.
- Latency: the last B byte is accepted on edge k; res_valid rises on edge k+1.
- HOLD:
  - res_valid=1; res_* and alu_* are held constant.
  - When res_valid && res_ready on an edge: res_valid goes to 0, op_count increments (wraps from 2^CNT_W-1 to 0), byte_cnt=0, state goes to LOAD_A.
  - alu_a and alu_b keep their old values until they are overwritten lane by lane.
- Bubbles: in_valid low in LOAD states stalls with no state change. res_ready held high in any state other than HOLD has no effect.
- clear has the highest priority, below only rst_n:
  - On an edge with clear=1: state goes to LOAD_A, byte_cnt=0, res_valid=0.
  - alu_a, alu_b, alu_sub_add and res_* are set to 0; op_count is unchanged.
  - A byte presented in the same cycle is dropped (not consumed).
- A reset asserted mid-load discards the partial operand. On release, the first accepted byte is A lane 0.
- Arithmetic is owned by the ALU; this block only captures values and never modifies flag values.

Decomposition:
- Shared package alu32_pkg holds:
  - DATA_W, BYTE_W, NUM_BYTES constants.
  - State enum {LOAD_A, LOAD_B, EXEC, HOLD}.
  - A result struct {data, carry, zero, overflow}.
- One natural sub-module: alu32_byte_asm, a DATA_W-wide register with lane-indexed byte write enable, synchronous clear and asynchronous reset. It is instantiated twice, for A and B.
- The FSM, counters and result register stay in the top module.

Test Plan:
1. Add:
   - Stimulus: bytes 78 56 34 12, 87 65 43 21 with in_op=0 on the last byte; res_ready=1.
   - Required response: alu_a=0x12345678, alu_b=0x21436587; res_valid one cycle after the last byte with res_data=0x3377BBFF, zero=0, overflow=0, carry=0; op_count goes 0 to 1.
2. Subtract to zero:
   - Stimulus: A=0x00000005, B=0x00000005, in_op=1.
   - Required response: res_data=0, res_zero=1, res_overflow=0.
3. Overflow with backpressure:
   - Stimulus: A=0x7FFFFFFF, B=0x00000001, add; res_ready=0 for 5 cycles.
   - Required response: res_valid is held with res_data=0x80000000 and res_overflow=1, all stable; in_ready=0 throughout; completion occurs on the first res_ready=1 edge.
4. Stalls:
   - Stimulus: in_valid toggled 1,0,0,1,... mid-operand.
   - Required response: only handshaked bytes land, in lanes 0..3 in order; the result matches the gap-free run.
5. Abort:
   - Stimulus: clear asserted after 2 bytes of B (plus an in_valid byte in the same cycle); then a full new sequence A=1, B=2, add.
   - Required response: alu_a=alu_b=0 after clear; the next result is 3; op_count is unchanged by the clear.
6. Reset and wrap:
   - Stimulus: rst_n pulsed low asynchronously mid-load; with CNT_W=2, four complete operations are run.
   - Required response: all outputs return to their reset values immediately on rst_n low; op_count goes 1, 2, 3, 0.
